// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU op encodings and RV64I opcode constants for the
//               ID-stage ALU issue path.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU op codes as seen on the ID/EX boundary; NOR is reserved and never issued
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_NOR = 4'b1100
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode
// Description : Combinational RV64I decode of one instruction word into ALU
//               op, sign-extended immediate and control flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     inst,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] imm,
  output logic            use_imm,
  output logic            reg_write,
  output logic            is_branch,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign f7b5   = inst[30];

  // rs1 field is resolved by the register file, not by this decoder
  logic unused_rs1_field;
  assign unused_rs1_field = ^inst[19:15];

  // Opcode/funct decode; defaults describe the unsupported case (no-writeback ADD on rs2)
  always_comb begin
    alu_op    = ALU_ADD;
    imm       = '0;
    use_imm   = 1'b0;
    reg_write = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        case (funct3)
          3'b000:  alu_op = f7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          default: begin
            reg_write = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_IMM: begin
        imm       = {{(XLEN-12){inst[31]}}, inst[31:20]};
        use_imm   = 1'b1;
        reg_write = 1'b1;
        case (funct3)
          3'b000:  alu_op = ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          default: begin
            imm       = '0;
            use_imm   = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        imm       = {{(XLEN-12){inst[31]}}, inst[31:20]};
        use_imm   = 1'b1;
        reg_write = 1'b1;
      end
      OP_STORE: begin
        imm     = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
        use_imm = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          alu_op    = ALU_SUB;
          is_branch = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule : alu_decode
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : ID-stage ALU producer. Decodes the instruction, selects
//               operand B and holds one ID/EX entry behind a valid/ready
//               handshake with flush.
//               Optional macro ALU_ILLEGAL_DET_EN adds the ex_illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_inst,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
`ifdef ALU_ILLEGAL_DET_EN
  output logic            ex_illegal,
`endif
  output logic            ex_is_branch
);

  alu_op_t         dec_alu_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_use_imm;
  logic            dec_reg_write;
  logic            dec_is_branch;
  logic            dec_illegal;
  logic            accept;

  alu_decode #(.XLEN(XLEN)) u_decode (
    .inst      (id_inst),
    .alu_op    (dec_alu_op),
    .imm       (dec_imm),
    .use_imm   (dec_use_imm),
    .reg_write (dec_reg_write),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal)
  );

  // The slot frees up whenever it is empty or being consumed this cycle
  assign id_ready = !ex_valid || ex_ready;
  assign accept   = id_valid && id_ready && !flush;

  // Slot occupancy: flush wins, then a new accept, then a drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid <= 1'b1;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Payload only moves on accept so it stays frozen under backpressure and after drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_a          <= '0;
      ex_b          <= '0;
      ex_alu_op     <= ALU_ADD;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_is_branch  <= 1'b0;
    end else if (accept) begin
      ex_a          <= id_rs1_data;
      ex_b          <= dec_use_imm ? dec_imm : id_rs2_data;
      ex_alu_op     <= dec_alu_op;
      ex_store_data <= id_rs2_data;
      ex_rd         <= dec_reg_write ? id_inst[11:7] : 5'd0;
      ex_reg_write  <= dec_reg_write;
      ex_is_branch  <= dec_is_branch;
    end
  end

`ifdef ALU_ILLEGAL_DET_EN
  // Illegal flag follows the payload but is also killed by flush alongside ex_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_illegal <= 1'b0;
    end else if (accept) begin
      ex_illegal <= dec_illegal;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = dec_illegal;
`endif

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking scoreboard bench for alu_issue_stage.
//               Honours ALU_ILLEGAL_DET_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_rs1_data;
  logic [63:0] id_rs2_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_a;
  logic [63:0] ex_b;
  logic [3:0]  ex_alu_op;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_branch;
`ifdef ALU_ILLEGAL_DET_EN
  logic        ex_illegal;
`endif

  int   checks;
  int   failures;
  exp_t sb_q[$];
  logic m_valid;

  alu_issue_stage #(.XLEN(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_inst       (id_inst),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_alu_op     (ex_alu_op),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
`ifdef ALU_ILLEGAL_DET_EN
    .ex_illegal    (ex_illegal),
`endif
    .ex_is_branch  (ex_is_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference decode written straight from the instruction-set table
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] a,
                                      input logic [63:0] b);
    exp_t e;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    opc   = inst[6:0];
    f3    = inst[14:12];
    imm_i = {{52{inst[31]}}, inst[31:20]};
    imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    e.a = a; e.b = b; e.op = 4'b0010; e.sd = b; e.rd = 5'd0;
    e.rw = 1'b0; e.br = 1'b0; e.ill = 1'b0;
    case (opc)
      7'h33: begin
        if (f3 == 3'd0)      begin e.op = inst[30] ? 4'b0110 : 4'b0010; e.rw = 1'b1; end
        else if (f3 == 3'd7) begin e.op = 4'b0000; e.rw = 1'b1; end
        else if (f3 == 3'd6) begin e.op = 4'b0001; e.rw = 1'b1; end
        else e.ill = 1'b1;
      end
      7'h13: begin
        if (f3 == 3'd0)      begin e.op = 4'b0010; e.b = imm_i; e.rw = 1'b1; end
        else if (f3 == 3'd7) begin e.op = 4'b0000; e.b = imm_i; e.rw = 1'b1; end
        else if (f3 == 3'd6) begin e.op = 4'b0001; e.b = imm_i; e.rw = 1'b1; end
        else e.ill = 1'b1;
      end
      7'h03: begin e.b = imm_i; e.rw = 1'b1; end
      7'h23: e.b = imm_s;
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1) begin e.op = 4'b0110; e.br = 1'b1; end
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (e.rw) e.rd = inst[11:7];
    return e;
  endfunction

  // One cycle: drive, check id_ready, update the model, clock, compare the slot
  task automatic step(input logic v, input logic [31:0] inst, input logic [63:0] a,
                      input logic [63:0] b, input logic rdy, input logic fl);
    logic acc;
    id_valid = v; id_inst = inst; id_rs1_data = a; id_rs2_data = b;
    ex_ready = rdy; flush = fl;
    #1;
    chk("id_ready", {63'd0, id_ready}, {63'd0, (!m_valid || rdy)});
    acc = v && (!m_valid || rdy) && !fl;
    if (m_valid && (rdy || fl) && sb_q.size() > 0) void'(sb_q.pop_front());
    if (acc) sb_q.push_back(ref_decode(inst, a, b));
    m_valid = fl ? 1'b0 : (acc ? 1'b1 : (rdy ? 1'b0 : m_valid));
    @(posedge clk);
    #1;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 64'd1, 64'd0);
      end else begin
        chk("ex_a",         ex_a,                  sb_q[0].a);
        chk("ex_b",         ex_b,                  sb_q[0].b);
        chk("ex_alu_op",    {60'd0, ex_alu_op},    {60'd0, sb_q[0].op});
        chk("ex_store",     ex_store_data,         sb_q[0].sd);
        chk("ex_rd",        {59'd0, ex_rd},        {59'd0, sb_q[0].rd});
        chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, sb_q[0].rw});
        chk("ex_is_branch", {63'd0, ex_is_branch}, {63'd0, sb_q[0].br});
`ifdef ALU_ILLEGAL_DET_EN
        chk("ex_illegal",   {63'd0, ex_illegal},   {63'd0, sb_q[0].ill});
`endif
      end
    end
`ifdef ALU_ILLEGAL_DET_EN
    if (fl) chk("ill_flush", {63'd0, ex_illegal}, 64'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"},  {63'd0, ex_valid},     64'd0);
    chk({tag, "_op"},     {60'd0, ex_alu_op},    64'd2);
    chk({tag, "_rd"},     {59'd0, ex_rd},        64'd0);
    chk({tag, "_a"},      ex_a,                  64'd0);
    chk({tag, "_b"},      ex_b,                  64'd0);
    chk({tag, "_sd"},     ex_store_data,         64'd0);
    chk({tag, "_rw"},     {63'd0, ex_reg_write}, 64'd0);
    chk({tag, "_br"},     {63'd0, ex_is_branch}, 64'd0);
`ifdef ALU_ILLEGAL_DET_EN
    chk({tag, "_ill"},    {63'd0, ex_illegal},   64'd0);
`endif
  endtask

  logic [31:0] pool [12];

  initial begin
    checks = 0; failures = 0; m_valid = 1'b0;
    id_valid = 1'b0; id_inst = '0; id_rs1_data = '0; id_rs2_data = '0;
    flush = 1'b0; ex_ready = 1'b0; rst_n = 1'b0;
    pool[0]  = 32'h40B50533; pool[1]  = 32'hFFF50513; pool[2]  = 32'h00A5B023;
    pool[3]  = 32'h00B57533; pool[4]  = 32'h00B56533; pool[5]  = 32'h00B50533;
    pool[6]  = 32'h00B50463; pool[7]  = 32'h0000007F; pool[8]  = 32'h0105B503;
    pool[9]  = 32'h8005E513; pool[10] = 32'h0FF57513; pool[11] = 32'hFEB52E23;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed decode cases, issued back-to-back with ex_ready high
    step(1'b1, 32'h40B50533, 64'd10, 64'd3, 1'b1, 1'b0);
    chk("sub_op_const", {60'd0, ex_alu_op}, 64'h6);
    chk("sub_rd_const", {59'd0, ex_rd}, 64'd10);
    step(1'b1, 32'hFFF50513, 64'd5, 64'd7, 1'b1, 1'b0);
    chk("addi_b_const", ex_b, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b1, 32'h00A5B023, 64'h100, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    chk("sd_b_const", ex_b, 64'd0);
    chk("sd_sd_const", ex_store_data, 64'hDEAD_BEEF_0123_4567);
    for (int i = 3; i < 12; i++)
      step(1'b1, pool[i], {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Backpressure: three held cycles then a bubble-free handoff
    step(1'b1, 32'h00B57533, 64'hAAAA, 64'h5555, 1'b1, 1'b0);
    repeat (3) step(1'b1, 32'h00B56533, 64'h1234, 64'h4321, 1'b0, 1'b0);
    step(1'b1, 32'h00B56533, 64'h1234, 64'h4321, 1'b1, 1'b0);
    step(1'b0, 32'h0, 64'd0, 64'd0, 1'b1, 1'b0);

    // Flush with a held entry and a same-cycle offer, with and without ex_ready
    step(1'b1, 32'h0000007F, 64'd1, 64'd2, 1'b1, 1'b0);
    step(1'b1, 32'h00B50533, 64'd3, 64'd4, 1'b0, 1'b1);
    step(1'b0, 32'h0, 64'd0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00B50463, 64'd5, 64'd6, 1'b1, 1'b0);
    step(1'b1, 32'h00B50533, 64'd7, 64'd8, 1'b1, 1'b1);

    // Mixed random traffic
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 3) != 0, pool[$urandom_range(0, 11)],
           {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);

    // Asynchronous reset while an entry is held
    step(1'b1, 32'h40B50533, 64'd10, 64'd3, 1'b1, 1'b0);
    step(1'b1, 32'h00B57533, 64'd1, 64'd1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_hold");
    sb_q.delete();
    m_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'hFFF50513, 64'd9, 64'd9, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_issue_stage
`default_nettype wire
